rr_priority_encoder: RTL and testbench



---
 rtl/rr_priority_encoder.sv | 100 ++++++++++
 tb/tb_rr_priority_encoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_encoder.sv
// Registered N-input arbiter/encoder: grants one active request as binary index d and one-hot oh,
// held under valid/ready. Round-robin when RR_PRIORITY_EN is defined, lowest-index-first otherwise.
module rr_priority_encoder #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         a,
  input  logic                 ready,
  output logic                 valid,
  output logic [$clog2(N)-1:0] d,
  output logic [N-1:0]         oh
);
  localparam int W = $clog2(N);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t       r_state;
  logic         r_valid;
  logic [W-1:0] r_d;
  logic [N-1:0] r_oh;

  logic [W-1:0] w_search_base;
  logic [W-1:0] w_win;
  logic         w_hit;
  logic [W:0]   w_sum;

`ifdef RR_PRIORITY_EN
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_next_ptr;

  assign w_next_ptr = (r_d == W'(N - 1)) ? '0 : r_d + W'(1);
  // On a handshake the new winner is searched from the advanced pointer in the same cycle.
  assign w_search_base = (r_state == S_HOLD) ? w_next_ptr : r_ptr;
`else
  assign w_search_base = '0;
`endif

  // Scan from the base upward, wrapping modulo N (not 2^W) so non-power-of-2 N stays in range.
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    w_sum = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, w_search_base} + (W+1)'(k);
      if (w_sum >= (W+1)'(N)) begin
        w_sum = w_sum - (W+1)'(N);
      end
      if (!w_hit && a[w_sum[W-1:0]]) begin
        w_hit = 1'b1;
        w_win = w_sum[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_d     <= '0;
      r_oh    <= '0;
`ifdef RR_PRIORITY_EN
      r_ptr   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_state <= S_HOLD;
            r_valid <= 1'b1;
            r_d     <= w_win;
            r_oh    <= N'(1) << w_win;
          end
        end
        S_HOLD: begin
          if (ready) begin
`ifdef RR_PRIORITY_EN
            r_ptr <= w_next_ptr;
`endif
            if (w_hit) begin
              r_valid <= 1'b1;
              r_d     <= w_win;
              r_oh    <= N'(1) << w_win;
            end else begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_oh    <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid = r_valid;
  assign d     = r_d;
  assign oh    = r_oh;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Self-checking bench for rr_priority_encoder (N=8): directed vector table plus a random phase
// checked against a behavioural model; expectations follow RR_PRIORITY_EN when defined.
module tb_rr_priority_encoder;
  localparam int N = 8;
  localparam int W = 3;
`ifdef RR_PRIORITY_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] a = '0;
  logic         ready = 1'b0;
  logic         valid;
  logic [W-1:0] d;
  logic [N-1:0] oh;

  always #5 clk = ~clk;

  rr_priority_encoder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .ready (ready),
    .valid (valid),
    .d     (d),
    .oh    (oh)
  );

  typedef struct {
    logic         rn;
    logic [N-1:0] a;
    logic         rdy;
    logic         v;
    logic [W-1:0] d;
    logic [N-1:0] oh;
    string        tag;
  } vec_t;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [N-1:0] oh;
    string        tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Behavioural reference: written from the handshake description, not the RTL structure.
  logic         m_hold = 1'b0;
  logic         m_v    = 1'b0;
  logic [W-1:0] m_d    = '0;
  logic [N-1:0] m_oh   = '0;
  int           m_ptr  = 0;

  function automatic void row(input logic rn, input logic [N-1:0] av, input logic rdy,
                              input logic v, input int dv, input string tag);
    vec_t r;
    r.rn  = rn;
    r.a   = av;
    r.rdy = rdy;
    r.v   = v;
    r.d   = W'(dv);
    r.oh  = v ? (N'(1) << dv) : '0;
    r.tag = tag;
    tbl.push_back(r);
  endfunction

  function automatic void model_grant(input logic [N-1:0] av);
    int base;
    base = RR ? m_ptr : 0;
    for (int k = 0; k < N; k++) begin
      if (av[(base + k) % N]) begin
        m_d  = W'((base + k) % N);
        m_oh = N'(1) << ((base + k) % N);
        m_v  = 1'b1;
        m_hold = 1'b1;
        return;
      end
    end
  endfunction

  function automatic void model_step(input logic rn, input logic [N-1:0] av, input logic rdy);
    if (!rn) begin
      m_hold = 1'b0; m_v = 1'b0; m_d = '0; m_oh = '0; m_ptr = 0;
    end else if (!m_hold) begin
      if (av != '0) model_grant(av);
    end else if (rdy) begin
      m_ptr = (int'(m_d) + 1) % N;
      if (av != '0) model_grant(av);
      else begin
        m_hold = 1'b0; m_v = 1'b0; m_oh = '0;
      end
    end
  endfunction

  task automatic apply(input vec_t r, input bit from_model);
    exp_t e;
    @(negedge clk);
    rst_n = r.rn;
    a     = r.a;
    ready = r.rdy;
    model_step(r.rn, r.a, r.rdy);
    e.v   = from_model ? m_v  : r.v;
    e.d   = from_model ? m_d  : r.d;
    e.oh  = from_model ? m_oh : r.oh;
    e.tag = r.tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(r);
  endtask

  task automatic check_out(input vec_t r);
    exp_t e;
    logic inv_ok;
    txn++;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: txn %0d had no expected entry", txn);
      return;
    end
    e = sb.pop_front();
    if (valid !== e.v || d !== e.d || oh !== e.oh) begin
      errors++;
      $display("FAIL %s: txn %0d got valid=%0b d=%0d oh=%02h, expected valid=%0b d=%0d oh=%02h",
               e.tag, txn, valid, d, oh, e.v, e.d, e.oh);
    end else begin
      $display("txn %0d %s: rst_n=%0b a=%02h ready=%0b -> valid=%0b d=%0d oh=%02h ok",
               txn, e.tag, r.rn, r.a, r.rdy, valid, d, oh);
    end
    checks++;
    inv_ok = valid ? (oh === (N'(1) << d)) : (oh === '0);
    if (!inv_ok) begin
      errors++;
      $display("FAIL onehot_invariant: txn %0d got valid=%0b d=%0d oh=%02h, expected oh=%02h",
               txn, valid, d, oh, valid ? (N'(1) << d) : '0);
    end
  endtask

  initial begin
    vec_t r;
    // Reset dominates a/ready, then first grant is index 0.
    row(0, 8'hFF, 1, 0, 0, "reset_0");
    row(0, 8'hFF, 1, 0, 0, "reset_1");
    row(1, 8'hFF, 0, 1, 0, "first_grant");
    row(1, 8'h00, 1, 0, 0, "drain_first");
    // Single request and release.
    row(1, 8'h20, 1, 1, 5, "single_req");
    row(1, 8'h00, 1, 0, 5, "single_release");
    // Hold stability, including a dropping to zero mid-hold.
    row(0, 8'h00, 0, 0, 0, "reset_hold");
    for (int i = 0; i < 5; i++) row(1, 8'h81, 0, 1, 0, "hold_stable");
    row(1, 8'h00, 0, 1, 0, "hold_a_dropped");
    row(1, 8'h00, 1, 0, 0, "hold_accept");
    // Continuous sweep with all requesters active.
    row(0, 8'h00, 0, 0, 0, "reset_sweep");
    for (int i = 0; i < 10; i++) row(1, 8'hFF, 1, 1, RR ? (i % N) : 0, "sweep");
    row(1, 8'h00, 1, 0, RR ? 1 : 0, "sweep_end");
    // Pointer wrap from 7 and skip over idle requesters.
    row(0, 8'h00, 0, 0, 0, "reset_wrap");
    row(1, 8'h80, 0, 1, 7, "wrap_grant7");
    row(1, 8'h81, 1, 1, 0, "wrap_to_0");
    row(1, 8'h81, 1, 1, RR ? 7 : 0, "skip_to_7");
    row(1, 8'h00, 1, 0, RR ? 7 : 0, "skip_release");
    // Reset in the middle of a held grant.
    row(0, 8'h00, 0, 0, 0, "reset_mid_pre");
    row(1, 8'h08, 0, 1, 3, "mid_grant3");
    row(1, 8'h00, 0, 1, 3, "mid_hold");
    row(0, 8'h08, 1, 0, 0, "mid_reset");
    row(1, 8'h18, 0, 1, 3, "post_reset_grant");
    row(1, 8'h00, 1, 0, 3, "post_reset_release");
    row(1, 8'h00, 1, 0, 3, "idle_ready_ignored");

    foreach (tbl[i]) apply(tbl[i], 1'b0);

    for (int i = 0; i < 200; i++) begin
      r.rn  = ($urandom_range(0, 39) != 0);
      r.a   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      r.rdy = 1'($urandom_range(0, 1));
      r.v   = 1'b0;
      r.d   = '0;
      r.oh  = '0;
      r.tag = "random";
      apply(r, 1'b1);
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
